// File: rtl/sd_sector_sched.sv
// ---------------------------------------------------------------------------
// sd_sector_sched
//   Schedules whole-sector reads from the SD card reader and streams the
//   returned bytes into the frame plexer. The SD reader cannot be stalled in
//   the middle of a sector, so a read is only issued while the downstream
//   main-data FIFO reports room for a complete sector.
//
// Parameters
//   SECTOR_BYTES  bytes returned per SD read (byte counter wraps here)
//   ADDR_SHIFT    o_sd_addr = sector << ADDR_SHIFT (9 = SDSC bytes, 0 = SDHC)
//   ROOM_W        width of the downstream free-space input
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start                 one-cycle pulse, begins a run (ignored while busy)
//   i_start_sector          first sector index, sampled on an accepted start
//   i_num_sectors           sectors to read, 0 = run until stopped
//   i_stop                  one-cycle pulse, run ends after the sector in flight
//   i_sd_ready              SD reader idle; dropping it acknowledges o_sd_rd
//   o_sd_rd, o_sd_addr      read request and its address (stable while o_sd_rd)
//   i_sd_byte_available     one-cycle pulse per returned byte
//   i_sd_dout               returned byte
//   i_room                  free bytes downstream
//   o_axiov, o_axiod        byte stream to the plexer (one cycle after the SD byte)
//   o_busy                  high from an accepted start until the run ends
//   o_done                  one-cycle pulse when the run ends
//   o_sectors_read          sectors completed this run (saturating)
//   o_overrun_err           sticky: a byte arrived outside STREAM
// ---------------------------------------------------------------------------
module sd_sector_sched #(
  parameter int unsigned SECTOR_BYTES = 512,
  parameter int unsigned ADDR_SHIFT   = 9,
  parameter int unsigned ROOM_W       = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [31:0]       i_start_sector,
  input  logic [23:0]       i_num_sectors,
  input  logic              i_stop,
  input  logic              i_sd_ready,
  output logic              o_sd_rd,
  output logic [31:0]       o_sd_addr,
  input  logic              i_sd_byte_available,
  input  logic [7:0]        i_sd_dout,
  input  logic [ROOM_W-1:0] i_room,
  output logic              o_axiov,
  output logic [7:0]        o_axiod,
  output logic              o_busy,
  output logic              o_done,
  output logic [23:0]       o_sectors_read,
  output logic              o_overrun_err
);

  localparam int unsigned CNT_W = (SECTOR_BYTES > 1) ? $clog2(SECTOR_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(SECTOR_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_STREAM,
    S_FINISH
  } state_t;

  state_t             r_state;
  logic [31:0]        r_sector;
  logic [23:0]        r_num;
  logic [23:0]        r_sectors_read;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic               r_stop_pend;
  logic               r_sd_rd;
  logic [31:0]        r_sd_addr;
  logic               r_axiov;
  logic [7:0]         r_axiod;
  logic               r_busy;
  logic               r_done;
  logic               r_overrun_err;

  logic               w_room_ok;
  logic               w_quota_met;

  // Room is compared unsigned against a full sector; a run with num=0 never
  // reaches its quota and only ends through stop.
  assign w_room_ok   = (32'(i_room) >= SECTOR_BYTES);
  assign w_quota_met = (r_num != '0) && (r_sectors_read == r_num);

  // Single FSM with registered outputs. axiov and done default low every
  // cycle so each is a one-cycle pulse when set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_sector       <= '0;
      r_num          <= '0;
      r_sectors_read <= '0;
      r_byte_cnt     <= '0;
      r_stop_pend    <= 1'b0;
      r_sd_rd        <= 1'b0;
      r_sd_addr      <= '0;
      r_axiov        <= 1'b0;
      r_axiod        <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_overrun_err  <= 1'b0;
    end else begin
      r_axiov <= 1'b0;
      r_done  <= 1'b0;

      // Stop is only remembered here; it takes effect at the next CHECK so
      // a sector already in flight always completes.
      if ((r_state != S_IDLE) && i_stop) begin
        r_stop_pend <= 1'b1;
      end

      // Bytes outside STREAM are never forwarded, only flagged.
      if ((r_state != S_STREAM) && i_sd_byte_available) begin
        r_overrun_err <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_sector       <= i_start_sector;
            r_num          <= i_num_sectors;
            r_sectors_read <= '0;
            r_overrun_err  <= 1'b0;
            r_stop_pend    <= 1'b0;
            r_busy         <= 1'b1;
            r_state        <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (r_stop_pend || w_quota_met) begin
            r_state <= S_FINISH;
          end else if (i_sd_ready && w_room_ok) begin
            r_sd_addr <= r_sector << ADDR_SHIFT;
            r_sd_rd   <= 1'b1;
            r_state   <= S_REQ;
          end
        end

        // The reader acknowledges by dropping sd_ready; until then the
        // request and address are held unchanged.
        S_REQ: begin
          if (!i_sd_ready) begin
            r_sd_rd    <= 1'b0;
            r_byte_cnt <= '0;
            r_state    <= S_STREAM;
          end
        end

        S_STREAM: begin
          if (i_sd_byte_available) begin
            r_axiov <= 1'b1;
            r_axiod <= i_sd_dout;
            if (r_byte_cnt == LAST_BYTE) begin
              r_byte_cnt <= '0;
              r_sector   <= r_sector + 32'd1;
              if (r_sectors_read != '1) begin
                r_sectors_read <= r_sectors_read + 24'd1;
              end
              r_state <= S_CHECK;
            end else begin
              r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
          end
        end

        S_FINISH: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_sd_rd        = r_sd_rd;
  assign o_sd_addr      = r_sd_addr;
  assign o_axiov        = r_axiov;
  assign o_axiod        = r_axiod;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_sectors_read = r_sectors_read;
  assign o_overrun_err  = r_overrun_err;

endmodule

// File: tb/tb_sd_sector_sched.sv
// ---------------------------------------------------------------------------
// tb_sd_sector_sched
//   Self-checking bench for sd_sector_sched. A small SD-reader emulator
//   answers read requests with 512 bytes at random pacing; a run-level model
//   predicts the address sequence, beat count, sector count and done pulse.
// ---------------------------------------------------------------------------
module tb_sd_sector_sched;

  localparam int SECTOR = 512;
  localparam int SHIFT  = 9;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic [31:0] startSector;
  logic [23:0] numSectors;
  logic        stop;
  logic        sdReady;
  logic        sdRd;
  logic [31:0] sdAddr;
  logic        sdByteAvail;
  logic [7:0]  sdDout;
  logic [11:0] room;
  logic        axiov;
  logic [7:0]  axiod;
  logic        busy;
  logic        done;
  logic [23:0] sectorsRead;
  logic        overrunErr;

  always #5 clk = ~clk;

  sd_sector_sched #(
    .SECTOR_BYTES(SECTOR),
    .ADDR_SHIFT  (SHIFT),
    .ROOM_W      (12)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rstN),
    .i_start            (start),
    .i_start_sector     (startSector),
    .i_num_sectors      (numSectors),
    .i_stop             (stop),
    .i_sd_ready         (sdReady),
    .o_sd_rd            (sdRd),
    .o_sd_addr          (sdAddr),
    .i_sd_byte_available(sdByteAvail),
    .i_sd_dout          (sdDout),
    .i_room             (room),
    .o_axiov            (axiov),
    .o_axiod            (axiod),
    .o_busy             (busy),
    .o_done             (done),
    .o_sectors_read     (sectorsRead),
    .o_overrun_err      (overrunErr)
  );

  typedef struct {
    logic [31:0] startSector;
    logic [23:0] num;
    logic [11:0] room;
    int          lowCycles;
    int          ackDelay;
    int          pulsePct;
    int          stopAt;
    bit          stopWithStart;
    bit          spamStart;
    int          expSectors;
    int          expBeats;
    logic [31:0] expFirstAddr;
  } vec_t;

  vec_t vecs[5];

  int checks = 0;
  int errors = 0;

  // emulator and run-model state
  int          emuPhase;
  int          emuWait;
  int          emuLeft;
  int          ackDelay;
  int          pulsePct;
  logic [31:0] runStart;
  int          reqIdx;
  logic [31:0] reqAddr;
  logic [31:0] firstAddr;
  bit          lastFwd;
  logic [7:0]  lastData;
  bit          injectNext;
  int          beatCount;
  int          doneCount;
  int          readsSeen;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic resetEmu();
    emuPhase    = 0;
    sdReady     = 1'b1;
    sdByteAvail = 1'b0;
    lastFwd     = 0;
    injectNext  = 0;
  endtask

  // One clock: at the falling edge check the stream against what the
  // emulator drove last cycle, then let the emulator drive the next cycle.
  task automatic cycle();
    logic [31:0] expAddr;
    @(negedge clk);
    checkOutput("axiov", {31'd0, axiov}, {31'd0, lastFwd});
    if (lastFwd) checkOutput("axiod", {24'd0, axiod}, {24'd0, lastData});
    if (axiov) beatCount++;
    if (done) doneCount++;

    sdByteAvail = 1'b0;
    lastFwd     = 0;
    case (emuPhase)
      0: begin
        sdReady = 1'b1;
        if (sdRd) begin
          readsSeen++;
          reqAddr = sdAddr;
          expAddr = (runStart + 32'(reqIdx)) << SHIFT;
          checkOutput("sd_addr", sdAddr, expAddr);
          if (reqIdx == 0) firstAddr = sdAddr;
          reqIdx++;
          if (ackDelay == 0) begin
            sdReady  = 1'b0;
            emuPhase = 2;
            emuLeft  = SECTOR;
          end else begin
            emuWait  = ackDelay;
            emuPhase = 1;
          end
        end
      end
      1: begin
        checkOutput("sd_rd_hold", {31'd0, sdRd}, 32'd1);
        checkOutput("sd_addr_stable", sdAddr, reqAddr);
        emuWait--;
        if (emuWait == 0) begin
          sdReady  = 1'b0;
          emuPhase = 2;
          emuLeft  = SECTOR;
        end
      end
      default: begin
        if (emuLeft > 0) begin
          if (int'($urandom_range(99)) < pulsePct) begin
            sdByteAvail = 1'b1;
            sdDout      = 8'($urandom);
            lastFwd     = 1;
            lastData    = sdDout;
            emuLeft--;
          end
        end else begin
          sdReady  = 1'b1;
          emuPhase = 0;
        end
      end
    endcase

    if (injectNext) begin
      sdByteAvail = 1'b1;
      sdDout      = 8'hA5;
      injectNext  = 0;
    end
  endtask

  task automatic clearRunModel(input logic [31:0] s, input int ack, input int pct);
    beatCount = 0;
    doneCount = 0;
    readsSeen = 0;
    reqIdx    = 0;
    firstAddr = 32'hDEAD_BEEF;
    runStart  = s;
    ackDelay  = ack;
    pulsePct  = pct;
  endtask

  // Runs one complete scheduling run described by a vector and checks the
  // run-level outcome.
  task automatic applyStimulus(input vec_t v);
    int  guard;
    bit  stopSent;
    bit  spamSent;
    clearRunModel(v.startSector, v.ackDelay, v.pulsePct);
    start       = 1'b1;
    startSector = v.startSector;
    numSectors  = v.num;
    room        = (v.lowCycles > 0) ? 12'd511 : v.room;
    stop        = v.stopWithStart;
    cycle();
    start = 1'b0;
    stop  = 1'b0;
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    checkOutput("overrun_cleared", {31'd0, overrunErr}, 32'd0);
    checkOutput("sectors_cleared", 32'(sectorsRead), 32'd0);

    if (v.lowCycles > 0) begin
      for (int c = 0; c < v.lowCycles; c++) begin
        cycle();
        checkOutput("rd_waits_room", {31'd0, sdRd}, 32'd0);
      end
      room = v.room;
      cycle();
      checkOutput("rd_on_room", {31'd0, sdRd}, 32'd1);
    end

    guard    = 0;
    stopSent = 0;
    spamSent = 0;
    while (doneCount == 0 && guard < 20000) begin
      stop  = 1'b0;
      start = 1'b0;
      if (v.stopAt >= 0 && beatCount == v.stopAt && !stopSent) begin
        stop     = 1'b1;
        stopSent = 1;
      end
      if (v.spamStart && beatCount == 10 && !spamSent) begin
        start       = 1'b1;
        startSector = ~v.startSector;
        numSectors  = 24'd7;
        spamSent    = 1;
      end
      cycle();
      guard++;
    end
    stop  = 1'b0;
    start = 1'b0;
    checkOutput("done_seen", 32'(doneCount), 32'd1);
    checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
    checkOutput("sectors_read", 32'(sectorsRead), 32'(v.expSectors));

    for (int c = 0; c < 6; c++) cycle();
    checkOutput("done_once", 32'(doneCount), 32'd1);
    checkOutput("reads_issued", 32'(readsSeen), 32'(v.expSectors));
    checkOutput("beats", 32'(beatCount), 32'(v.expBeats));
    checkOutput("first_addr", firstAddr, v.expFirstAddr);
    checkOutput("sectors_hold", 32'(sectorsRead), 32'(v.expSectors));
  endtask

  initial begin
    vec_t rv;
    int   guard;

    vecs[0] = '{32'd5, 24'd2, 12'd4095, 0, 0, 60, -1, 1'b0, 1'b0, 2, 1024, 32'h0000_0A00};
    vecs[1] = '{32'd9, 24'd1, 12'd512, 20, 0, 50, -1, 1'b0, 1'b0, 1, 512, 32'h0000_1200};
    vecs[2] = '{32'd0, 24'd0, 12'd2048, 0, 1, 80, 3 * 512 + 100, 1'b0, 1'b0, 4, 2048, 32'h0};
    vecs[3] = '{32'd7, 24'd1, 12'd1024, 0, 3, 50, -1, 1'b0, 1'b1, 1, 512, 32'h0000_0E00};
    vecs[4] = '{32'hFFFF_FFFF, 24'd2, 12'd512, 0, 2, 70, -1, 1'b1, 1'b0, 2, 1024, 32'hFFFF_FE00};

    rstN        = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    startSector = '0;
    numSectors  = '0;
    room        = '0;
    sdDout      = '0;
    resetEmu();
    clearRunModel(32'd0, 0, 50);

    repeat (3) cycle();
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_sd_rd", {31'd0, sdRd}, 32'd0);
    checkOutput("reset_sd_addr", sdAddr, 32'd0);
    checkOutput("reset_sectors", 32'(sectorsRead), 32'd0);
    checkOutput("reset_overrun", {31'd0, overrunErr}, 32'd0);
    rstN = 1'b1;
    cycle();

    // a stop while idle must not leave anything pending for the next run
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    checkOutput("idle_stop_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i]);
    end

    for (int r = 0; r < 4; r++) begin
      rv.startSector   = $urandom;
      rv.num           = 24'($urandom_range(3, 1));
      rv.room          = 12'($urandom_range(4095, 512));
      rv.lowCycles     = 0;
      rv.ackDelay      = int'($urandom_range(3, 0));
      rv.pulsePct      = int'($urandom_range(100, 40));
      rv.stopAt        = -1;
      rv.stopWithStart = 1'b0;
      rv.spamStart     = 1'($urandom_range(1, 0));
      rv.expSectors    = int'(rv.num);
      rv.expBeats      = SECTOR * int'(rv.num);
      rv.expFirstAddr  = rv.startSector << SHIFT;
      $display("[TB] random run %0d start=0x%0h num=%0d", r, rv.startSector, rv.num);
      applyStimulus(rv);
    end

    // stray byte while waiting in CHECK: flagged, not forwarded, sticky
    $display("[TB] overrun sequence");
    clearRunModel(32'h10, 0, 50);
    start       = 1'b1;
    startSector = 32'h10;
    numSectors  = 24'd1;
    room        = 12'd0;
    cycle();
    start = 1'b0;
    cycle();
    injectNext = 1;
    cycle();
    cycle();
    checkOutput("overrun_set", {31'd0, overrunErr}, 32'd1);
    checkOutput("overrun_no_fwd", {31'd0, axiov}, 32'd0);
    checkOutput("overrun_no_read", 32'(readsSeen), 32'd0);
    stop = 1'b1;
    cycle();
    stop  = 1'b0;
    guard = 0;
    while (doneCount == 0 && guard < 10) begin
      cycle();
      guard++;
    end
    checkOutput("overrun_done", 32'(doneCount), 32'd1);
    checkOutput("overrun_sectors", 32'(sectorsRead), 32'd0);
    cycle();
    checkOutput("overrun_sticky", {31'd0, overrunErr}, 32'd1);
    checkOutput("overrun_beats", 32'(beatCount), 32'd0);
    applyStimulus(vecs[3]);

    // asynchronous reset in the middle of a sector
    $display("[TB] reset sequence");
    clearRunModel(32'h20, 0, 70);
    start       = 1'b1;
    startSector = 32'h20;
    numSectors  = 24'd1;
    room        = 12'd4095;
    cycle();
    start = 1'b0;
    guard = 0;
    while (beatCount < 50 && guard < 2000) begin
      cycle();
      guard++;
    end
    checkOutput("reached_stream", {31'd0, beatCount >= 50}, 32'd1);
    checkOutput("mid_stream_addr", sdAddr, 32'h0000_4000);
    #1 rstN = 1'b0;
    #1;
    checkOutput("async_busy", {31'd0, busy}, 32'd0);
    checkOutput("async_axiov", {31'd0, axiov}, 32'd0);
    checkOutput("async_axiod", {24'd0, axiod}, 32'd0);
    checkOutput("async_sd_rd", {31'd0, sdRd}, 32'd0);
    checkOutput("async_sd_addr", sdAddr, 32'd0);
    checkOutput("async_done", {31'd0, done}, 32'd0);
    checkOutput("async_overrun", {31'd0, overrunErr}, 32'd0);
    checkOutput("async_sectors", 32'(sectorsRead), 32'd0);
    resetEmu();
    cycle();
    cycle();
    rstN = 1'b1;
    beatCount = 0;
    injectNext = 1;
    cycle();
    cycle();
    checkOutput("idle_no_fwd", 32'(beatCount), 32'd0);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("idle_no_rd", {31'd0, sdRd}, 32'd0);
    checkOutput("idle_overrun", {31'd0, overrunErr}, 32'd1);
    applyStimulus(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
